// File: rtl/sram_ctrl_arb_pkg.sv
// Shared types and defaults for the dual-port SRAM controller/arbiter.
package sram_ctrl_arb_pkg;

   localparam int AW_DEFAULT        = 12;
   localparam int DW_DEFAULT        = 8;
   localparam int WR_CYCLES_DEFAULT = 2;

   // Requester identity: 0 = port 0, 1 = port 1
   typedef logic port_id_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_WREC,
      ST_SENSE,
      ST_CAPT
   } state_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last granted port;
// on a tie the other port wins. Reset leaves the pointer on port 1 so that
// port 0 wins the first tie.
module sram_rr_arb2
   import sram_ctrl_arb_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     req0,
   input  logic     req1,
   input  logic     accept,
   output port_id_t winner,
   output logic     any_req
);

   port_id_t last_reg;

   // Pick the winner from the current requests and the last-grant pointer
   always_comb begin
      any_req = req0 | req1;
      if (req0 && req1) begin
         winner = ~last_reg;
      end else if (req1) begin
         winner = 1'b1;
      end else begin
         winner = 1'b0;
      end
   end

   // Advance the pointer only when the controller actually takes a command
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_reg <= 1'b1;
      end else if (accept) begin
         last_reg <= winner;
      end
   end

endmodule

// File: rtl/sram_ctrl_arb.sv
// SRAM controller with two command ports. Commands are accepted only in
// IDLE; writes hold write_en for WR_CYCLES then recover one cycle, reads
// pulse sense_en low for one cycle and capture dout in the following cycle.
module sram_ctrl_arb
   import sram_ctrl_arb_pkg::*;
#(
   parameter int AW        = AW_DEFAULT,
   parameter int DW        = DW_DEFAULT,
   parameter int WR_CYCLES = WR_CYCLES_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] rdata,
   output logic          rvalid,
   output port_id_t      rvalid_id,
   output logic          busy,
   output logic          sram_write_en,
   output logic          sram_sense_en,
   output logic [AW-1:0] sram_addr,
   output logic [DW-1:0] sram_din,
   input  logic [DW-1:0] sram_dout
);

   localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WR_CYCLES - 1);

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   port_id_t      port_reg;
   port_id_t      winner;
   logic          any_req;
   logic          accept;
   logic          capture;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   sram_rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req0    (req0),
      .req1    (req1),
      .accept  (accept),
      .winner  (winner),
      .any_req (any_req)
   );

   // Route the winning port's command fields
   always_comb begin
      sel_we    = winner ? we1    : we0;
      sel_addr  = winner ? addr1  : addr0;
      sel_wdata = winner ? wdata1 : wdata0;
   end

   // Next-state and array strobes; grants are gated by reset so nothing
   // leaks out while reset is asserted
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      accept        = 1'b0;
      capture       = 1'b0;
      gnt0          = 1'b0;
      gnt1          = 1'b0;
      busy          = 1'b1;
      sram_write_en = 1'b0;
      sram_sense_en = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (any_req && !reset) begin
               accept     = 1'b1;
               gnt0       = (winner == 1'b0);
               gnt1       = (winner == 1'b1);
               cnt_next   = '0;
               state_next = sel_we ? ST_WRITE : ST_SENSE;
            end
         end
         ST_WRITE: begin
            sram_write_en = 1'b1;
            if (cnt_reg == CNT_LAST) begin
               state_next = ST_WREC;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         ST_WREC: begin
            state_next = ST_IDLE;
         end
         ST_SENSE: begin
            sram_sense_en = 1'b0;
            state_next    = ST_CAPT;
         end
         ST_CAPT: begin
            capture    = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, command registers and read-return registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         port_reg  <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         rvalid_id <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         rvalid    <= capture;
         if (accept) begin
            port_reg  <= winner;
            sram_addr <= sel_addr;
            sram_din  <= sel_wdata;
         end
         if (capture) begin
            rdata     <= sram_dout;
            rvalid_id <= port_reg;
         end
      end
   end

endmodule

// File: tb/tb_sram_ctrl_arb.sv
// Self-checking bench for sram_ctrl_arb: directed table, hand sequences for
// multi-cycle corners, and random write/read-back pairs against a memory model.
module tb_sram_ctrl_arb;

   localparam int AW  = 12;
   localparam int DW  = 8;
   localparam int WRC = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          rvalid_id;
   logic          busy;
   logic          sram_write_en, sram_sense_en;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout = '0;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   logic rv_prev  = 1'b0;

   // Expected array contents (behavioural scoreboard)
   logic [DW-1:0] sb [0:4095];

   // Array model: writes while write_en, sense latches dout while sense_en low
   logic [DW-1:0] mem [0:4095];

   sram_ctrl_arb #(.AW(AW), .DW(DW), .WR_CYCLES(WRC)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rdata(rdata), .rvalid(rvalid),
      .rvalid_id(rvalid_id), .busy(busy),
      .sram_write_en(sram_write_en), .sram_sense_en(sram_sense_en),
      .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (sram_write_en) mem[sram_addr] <= sram_din;
      if (!sram_sense_en) sram_dout <= mem[sram_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Continuous invariants: strobes never overlap, rvalid is a single pulse
   always @(negedge clk) begin
      chk("strobe_overlap", 32'(sram_write_en & ~sram_sense_en), 32'd0);
      chk("rvalid_single", 32'(rvalid & rv_prev), 32'd0);
      rv_prev <= rvalid;
   end

   task automatic idle_inputs();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (p == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
      else        begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
   endtask

   task automatic drop_req(input int p);
      if (p == 0) req0 = 0; else req1 = 0;
   endtask

   // One command from an idle controller, checked end to end
   task automatic run_cmd(input int p, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input string tag);
      int wcnt, scnt, done_k, rv_k;
      logic got;
      logic [DW-1:0] rv_d;
      logic rv_id;
      @(posedge clk); #1;
      set_req(p, we, a, d);
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if ((p == 0) ? gnt0 : gnt1) got = 1;
      end
      chk({tag, " gnt"}, 32'(got), 32'd1);
      chk({tag, " other_gnt"}, 32'((p == 0) ? gnt1 : gnt0), 32'd0);
      if (!got) begin
         idle_inputs();
         return;
      end
      @(posedge clk); #1;
      drop_req(p);
      wcnt = 0; scnt = 0; done_k = 0; rv_k = 0; rv_d = '0; rv_id = 0;
      for (int k = 1; k <= 20 && done_k == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            chk({tag, " sram_addr"}, 32'(sram_addr), 32'(a));
            if (we) chk({tag, " sram_din"}, 32'(sram_din), 32'(d));
         end
         wcnt += int'(sram_write_en);
         scnt += int'(!sram_sense_en);
         if (rvalid) begin rv_k = k; rv_d = rdata; rv_id = rvalid_id; end
         if (!busy) done_k = k;
      end
      chk({tag, " idle_after"}, 32'(done_k), we ? 32'(WRC + 2) : 32'd3);
      chk({tag, " write_en_cycles"}, 32'(wcnt), we ? 32'(WRC) : 32'd0);
      chk({tag, " sense_cycles"}, 32'(scnt), we ? 32'd0 : 32'd1);
      chk({tag, " rvalid_cycle"}, 32'(rv_k), we ? 32'd0 : 32'd3);
      if (!we) begin
         chk({tag, " rdata"}, 32'(rv_d), 32'(exp_rd));
         chk({tag, " rvalid_id"}, 32'(rv_id), 32'(p));
      end
      $display("TXN %s port=%0d %s addr=0x%03h data=0x%02h", tag, p, we ? "WR" : "RD", a,
               we ? d : rv_d);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int g1, g2, scnt, ng0, ng1, nrv, wcnt, gi;
      logic drop, move;
      logic [DW-1:0] rvq [$];
      int idq [$];

      vecs[0] = '{0, 1'b1, 12'h123, 8'hA5, 8'h00};
      vecs[1] = '{0, 1'b0, 12'h123, 8'h00, 8'hA5};
      vecs[2] = '{1, 1'b1, 12'h000, 8'h11, 8'h00};
      vecs[3] = '{0, 1'b1, 12'hFFF, 8'hEE, 8'h00};
      vecs[4] = '{0, 1'b0, 12'h000, 8'h00, 8'h11};
      vecs[5] = '{1, 1'b0, 12'hFFF, 8'h00, 8'hEE};

      for (int i = 0; i < 4096; i++) begin mem[i] = '0; sb[i] = '0; end
      idle_inputs();

      // Reset state with a request pending: nothing may be granted
      req0 = 1; req1 = 1;
      repeat (3) @(negedge clk);
      chk("rst gnt0", 32'(gnt0), 32'd0);
      chk("rst gnt1", 32'(gnt1), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst rvalid", 32'(rvalid), 32'd0);
      chk("rst rvalid_id", 32'(rvalid_id), 32'd0);
      chk("rst rdata", 32'(rdata), 32'd0);
      chk("rst write_en", 32'(sram_write_en), 32'd0);
      chk("rst sense_en", 32'(sram_sense_en), 32'd1);
      chk("rst sram_addr", 32'(sram_addr), 32'd0);
      chk("rst sram_din", 32'(sram_din), 32'd0);
      idle_inputs();
      reset = 0;

      // Directed table
      for (int i = 0; i < 6; i++) begin
         run_cmd(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                 $sformatf("vec%0d", i));
         if (vecs[i].we) sb[vecs[i].addr] = vecs[i].wdata;
      end

      // Back-to-back reads on port 0: 0x000 then 0xFFF with req held
      g1 = -1; g2 = -1; scnt = 0; drop = 0; move = 0;
      rvq.delete();
      for (int t = 0; t < 12; t++) begin
         @(posedge clk); #1;
         if (t == 0) set_req(0, 1'b0, 12'h000, 8'h00);
         if (move) begin addr0 = 12'hFFF; move = 0; end
         if (drop) begin req0 = 0; drop = 0; end
         @(negedge clk);
         scnt += int'(!sram_sense_en);
         if (rvalid) rvq.push_back(rdata);
         if (gnt0) begin
            if (g1 < 0) begin g1 = cyc; move = 1; end
            else if (g2 < 0) begin g2 = cyc; drop = 1; end
         end
      end
      chk("b2b second_gnt_gap", 32'(g2 - g1), 32'd3);
      chk("b2b sense_cycles", 32'(scnt), 32'd2);
      chk("b2b rvalid_count", 32'(rvq.size()), 32'd2);
      if (rvq.size() == 2) begin
         chk("b2b rdata0", 32'(rvq[0]), 32'h11);
         chk("b2b rdata1", 32'(rvq[1]), 32'hEE);
      end
      $display("TXN b2b reads 0x000/0xFFF gnt gap=%0d", g2 - g1);
      idle_inputs();

      // Both ports requesting continuously: grants alternate from port 0
      pulse_reset();
      gi = 0; drop = 0; nrv = 0;
      idq.delete();
      for (int t = 0; t < 18; t++) begin
         @(posedge clk); #1;
         if (t == 0) begin
            set_req(0, 1'b0, 12'h001, 8'h00);
            set_req(1, 1'b0, 12'h002, 8'h00);
         end
         if (drop) begin req0 = 0; req1 = 0; drop = 0; end
         @(negedge clk);
         if (gnt0 | gnt1) begin
            chk("alt single_gnt", 32'(gnt0 & gnt1), 32'd0);
            chk($sformatf("alt winner%0d", gi), 32'(gnt1), 32'(gi % 2));
            idq.push_back(gi % 2);
            $display("TXN alt grant%0d port=%0d", gi, gnt1 ? 1 : 0);
            gi++;
            if (gi == 4) drop = 1;
         end
         if (rvalid) begin
            nrv++;
            if (idq.size() > 0) chk("alt rvalid_id", 32'(rvalid_id), 32'(idq.pop_front()));
            else chk("alt rvalid_unexpected", 32'd1, 32'd0);
         end
      end
      chk("alt grant_count", 32'(gi), 32'd4);
      chk("alt rvalid_count", 32'(nrv), 32'd4);
      idle_inputs();

      // Port 1 request raised and withdrawn while port 0 writes
      ng0 = 0; ng1 = 0; wcnt = 0; scnt = 0; nrv = 0; drop = 0;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk); #1;
         if (t == 0) set_req(0, 1'b1, 12'h050, 8'h77);
         if (drop) begin req0 = 0; drop = 0; end
         if (t == 1) set_req(1, 1'b1, 12'h0AA, 8'h99);
         if (t == 2) req1 = 0;
         @(negedge clk);
         if (gnt0) begin ng0++; drop = 1; end
         ng1 += int'(gnt1);
         wcnt += int'(sram_write_en);
         scnt += int'(!sram_sense_en);
         nrv += int'(rvalid);
      end
      chk("drop gnt0_count", 32'(ng0), 32'd1);
      chk("drop gnt1_count", 32'(ng1), 32'd0);
      chk("drop write_en_cycles", 32'(wcnt), 32'(WRC));
      chk("drop sense_cycles", 32'(scnt), 32'd0);
      chk("drop rvalid_count", 32'(nrv), 32'd0);
      chk("drop port1_addr_untouched", 32'(mem[12'h0AA]), 32'(sb[12'h0AA]));
      $display("TXN dropped req1 while port0 wrote 0x050");
      sb[12'h050] = 8'h77;
      idle_inputs();
      run_cmd(0, 1'b0, 12'h050, 8'h00, sb[12'h050], "drop_rb");

      // Random write/read-back pairs
      for (int i = 0; i < 100; i++) begin
         int wp, rp;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         wp = int'($urandom_range(0, 1));
         rp = int'($urandom_range(0, 1));
         a  = AW'($urandom_range(0, 4095));
         d  = DW'($urandom);
         run_cmd(wp, 1'b1, a, d, 8'h00, $sformatf("rnd%0d_wr", i));
         sb[a] = d;
         run_cmd(rp, 1'b0, a, 8'h00, sb[a], $sformatf("rnd%0d_rd", i));
      end

      // Reset during the write of 0x3C to 0xFFF
      drop = 0; wcnt = 0;
      for (int t = 0; t < 2; t++) begin
         @(posedge clk); #1;
         if (t == 0) set_req(0, 1'b1, 12'hFFF, 8'h3C);
         if (drop) begin req0 = 0; drop = 0; end
         @(negedge clk);
         if (gnt0) drop = 1;
      end
      chk("rstw in_write", 32'(sram_write_en), 32'd1);
      reset = 1;
      #1;
      chk("rstw write_en", 32'(sram_write_en), 32'd0);
      chk("rstw busy", 32'(busy), 32'd0);
      chk("rstw sense_en", 32'(sram_sense_en), 32'd1);
      chk("rstw sram_addr", 32'(sram_addr), 32'd0);
      chk("rstw sram_din", 32'(sram_din), 32'd0);
      chk("rstw rvalid", 32'(rvalid), 32'd0);
      chk("rstw rdata", 32'(rdata), 32'd0);
      chk("rstw gnt", 32'(gnt0 | gnt1), 32'd0);
      repeat (2) @(negedge clk);
      reset = 0;
      ng0 = 0; nrv = 0; wcnt = 0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         ng0 += int'(gnt0 | gnt1);
         nrv += int'(rvalid);
         wcnt += int'(busy);
      end
      chk("rstw no_gnt_after", 32'(ng0), 32'd0);
      chk("rstw no_rvalid_after", 32'(nrv), 32'd0);
      chk("rstw no_busy_after", 32'(wcnt), 32'd0);
      $display("TXN reset during write 0xFFF aborted");
      @(posedge clk); #1;
      set_req(0, 1'b0, 12'h005, 8'h00);
      set_req(1, 1'b0, 12'h006, 8'h00);
      @(negedge clk);
      chk("rstw first_gnt0", 32'(gnt0), 32'd1);
      chk("rstw first_gnt1", 32'(gnt1), 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      for (int t = 0; t < 20 && busy; t++) @(negedge clk);
      chk("rstw drained", 32'(busy), 32'd0);
      $display("TXN post-reset grant port=%0d", 0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
